// File: rtl/maze_move_responder.sv
// Maze move responder: holds a small open/wall bitmap, walks a cursor from (0,0) under
// handshaked move commands and reports each move's outcome one cycle after acceptance.
// Optional feature: define MAZE_BACKTRACK_EN to enable the position stack behind code 111.
module maze_move_responder #(
  parameter int unsigned W         = 10,
  parameter int unsigned H         = 10,
  parameter int unsigned MAX_STEPS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       maze_wr_en,
  input  logic [3:0] maze_wr_x,
  input  logic [3:0] maze_wr_y,
  input  logic       maze_wr_open,
  input  logic       start,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_dir,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic       rsp_ok,
  output logic [3:0] x_pos,
  output logic [3:0] y_pos,
  output logic       found,
  output logic [6:0] step_cnt,
  output logic       busy
);

  localparam logic [4:0] WLim     = 5'(W);
  localparam logic [4:0] HLim     = 5'(H);
  localparam logic [3:0] GoalX    = 4'(W - 1);
  localparam logic [3:0] GoalY    = 4'(H - 1);
  localparam logic [6:0] MaxSteps = 7'(MAX_STEPS);

  typedef enum logic [1:0] {StIdle, StRun, StResp, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        x_q, x_d, y_q, y_d;
  logic [6:0]        step_q, step_d;
  logic              found_q, found_d, ok_q, ok_d;
  // Bitmaps are sized 16x16 and indexed [y][x]; cells outside W x H are never written.
  logic [15:0][15:0] maze_q;
  logic [15:0][15:0] vis_q, vis_d;

  logic       accept, is_move, in_range, move_ok, bt_ok;
  logic [4:0] tx, ty;
  logic [3:0] bt_x, bt_y;

  assign accept = cmd_valid && (state_q == StRun) && !start;

  // Decode the direction into a candidate target cell and its range check.
  always_comb begin
    tx       = {1'b0, x_q};
    ty       = {1'b0, y_q};
    is_move  = 1'b0;
    in_range = 1'b0;
    case (cmd_dir)
      3'b000: begin
        is_move  = 1'b1;
        in_range = (y_q != 4'd0);
        ty       = ty - 5'd1;
      end
      3'b001: begin
        is_move  = 1'b1;
        ty       = ty + 5'd1;
        in_range = (ty < HLim);
      end
      3'b010: begin
        is_move  = 1'b1;
        in_range = (x_q != 4'd0);
        tx       = tx - 5'd1;
      end
      3'b011: begin
        is_move  = 1'b1;
        tx       = tx + 5'd1;
        in_range = (tx < WLim);
      end
      default: ;
    endcase
  end

  // The step limit gate also makes step_cnt saturate at MAX_STEPS.
  assign move_ok = is_move && in_range && maze_q[ty[3:0]][tx[3:0]] &&
                   !vis_q[ty[3:0]][tx[3:0]] && (step_q < MaxSteps);

`ifdef MAZE_BACKTRACK_EN
  // Stack depth always equals step_cnt, so step_cnt doubles as the stack pointer.
  logic [7:0] stack_q [128];

  assign bt_ok        = (cmd_dir == 3'b111) && (step_q != 7'd0);
  assign {bt_x, bt_y} = stack_q[step_q - 7'd1];

  // Push the departed position on every successful move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) stack_q[i] <= '0;
    end else if (accept && move_ok) begin
      stack_q[step_q] <= {x_q, y_q};
    end
  end
`else
  assign bt_ok = 1'b0;
  assign bt_x  = x_q;
  assign bt_y  = y_q;
`endif

  // Next-state and session bookkeeping; start overrides everything else.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = step_q;
    found_d = found_q;
    ok_d    = ok_q;
    vis_d   = vis_q;
    if (start) begin
      state_d     = StRun;
      x_d         = 4'd0;
      y_d         = 4'd0;
      step_d      = 7'd0;
      found_d     = 1'b0;
      ok_d        = 1'b0;
      vis_d       = '0;
      vis_d[0][0] = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (cmd_valid) begin
            state_d = StResp;
            ok_d    = 1'b0;
            if (move_ok) begin
              ok_d                     = 1'b1;
              x_d                      = tx[3:0];
              y_d                      = ty[3:0];
              vis_d[ty[3:0]][tx[3:0]]  = 1'b1;
              step_d                   = step_q + 7'd1;
              if (tx[3:0] == GoalX && ty[3:0] == GoalY) found_d = 1'b1;
            end else if (cmd_dir == 3'b110) begin
              ok_d = 1'b1;
            end else if (bt_ok) begin
              ok_d             = 1'b1;
              vis_d[y_q][x_q]  = 1'b0;
              x_d              = bt_x;
              y_d              = bt_y;
              step_d           = step_q - 7'd1;
            end
          end
        end
        StResp:  state_d = found_q ? StDone : StRun;
        default: ;
      endcase
    end
  end

  // Session state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      step_q  <= '0;
      found_q <= 1'b0;
      ok_q    <= 1'b0;
      vis_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      found_q <= found_d;
      ok_q    <= ok_d;
      vis_q   <= vis_d;
    end
  end

  // Maze bitmap: writable only outside a live session and only for in-range cells.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maze_q <= '0;
    end else if (maze_wr_en && (state_q == StIdle || state_q == StDone) &&
                 ({1'b0, maze_wr_x} < WLim) && ({1'b0, maze_wr_y} < HLim)) begin
      maze_q[maze_wr_y][maze_wr_x] <= maze_wr_open;
    end
  end

  assign cmd_ready = (state_q == StRun);
  assign rsp_valid = (state_q == StResp);
  assign rsp_ok    = ok_q && (state_q == StResp);
  assign busy      = (state_q == StRun) || (state_q == StResp);
  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign found     = found_q;
  assign step_cnt  = step_q;

endmodule

// File: tb/tb_maze_move_responder.sv
// Bench for maze_move_responder: two instances (MAX_STEPS 50 and 4), a reference model of
// the maze walk and a scoreboard monitor that checks every response as it appears.
module tb_maze_move_responder;

  localparam int GW = 10;
  localparam int GH = 10;
`ifdef MAZE_BACKTRACK_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], wr_en[2], wr_open[2], start[2], cmd_valid[2];
  logic [3:0] wr_x[2], wr_y[2];
  logic [2:0] cmd_dir[2];
  logic       cmd_ready[2], rsp_valid[2], rsp_ok[2], found[2], busy[2];
  logic [3:0] x_pos[2], y_pos[2];
  logic [6:0] step_cnt[2];

  maze_move_responder #(.W(GW), .H(GH), .MAX_STEPS(50)) dut (
    .clk(clk), .rst(rst[0]), .maze_wr_en(wr_en[0]), .maze_wr_x(wr_x[0]),
    .maze_wr_y(wr_y[0]), .maze_wr_open(wr_open[0]), .start(start[0]),
    .cmd_valid(cmd_valid[0]), .cmd_dir(cmd_dir[0]), .cmd_ready(cmd_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ok(rsp_ok[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]),
    .found(found[0]), .step_cnt(step_cnt[0]), .busy(busy[0])
  );

  maze_move_responder #(.W(GW), .H(GH), .MAX_STEPS(4)) dut4 (
    .clk(clk), .rst(rst[1]), .maze_wr_en(wr_en[1]), .maze_wr_x(wr_x[1]),
    .maze_wr_y(wr_y[1]), .maze_wr_open(wr_open[1]), .start(start[1]),
    .cmd_valid(cmd_valid[1]), .cmd_dir(cmd_dir[1]), .cmd_ready(cmd_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ok(rsp_ok[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]),
    .found(found[1]), .step_cnt(step_cnt[1]), .busy(busy[1])
  );

  // Reference model state, indexed [instance][x][y].
  typedef struct {
    bit ok;
    int x;
    int y;
    int st;
    bit fd;
  } exp_t;

  int   max_steps[2] = '{50, 4};
  bit   mz[2][16][16];
  bit   vis[2][16][16];
  int   px[2], py[2], steps[2], depth[2];
  int   hist_x[2][128], hist_y[2][128];
  bit   fnd[2], in_sess[2];
  exp_t sbq0[$], sbq1[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset(input int k);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        mz[k][x][y]  = 1'b0;
        vis[k][x][y] = 1'b0;
      end
    px[k] = 0; py[k] = 0; steps[k] = 0; depth[k] = 0; fnd[k] = 1'b0; in_sess[k] = 1'b0;
    if (k == 0) sbq0.delete(); else sbq1.delete();
  endfunction

  function automatic void model_start(input int k);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) vis[k][x][y] = 1'b0;
    vis[k][0][0] = 1'b1;
    px[k] = 0; py[k] = 0; steps[k] = 0; depth[k] = 0; fnd[k] = 1'b0; in_sess[k] = 1'b1;
  endfunction

  function automatic void model_cmd(input int k, input int dir);
    int   nx = px[k];
    int   ny = py[k];
    bit   ok = 1'b0;
    bit   mv = 1'b1;
    exp_t e;
    case (dir)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      3: nx = nx + 1;
      default: mv = 1'b0;
    endcase
    if (mv) begin
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH && steps[k] < max_steps[k])
        ok = mz[k][nx][ny] && !vis[k][nx][ny];
      if (ok) begin
        hist_x[k][depth[k]] = px[k];
        hist_y[k][depth[k]] = py[k];
        depth[k]++;
        px[k] = nx; py[k] = ny; vis[k][nx][ny] = 1'b1; steps[k]++;
        if (nx == GW - 1 && ny == GH - 1) fnd[k] = 1'b1;
      end
    end else if (dir == 6) begin
      ok = 1'b1;
    end else if (dir == 7 && BT && depth[k] > 0) begin
      ok = 1'b1;
      vis[k][px[k]][py[k]] = 1'b0;
      depth[k]--;
      px[k] = hist_x[k][depth[k]];
      py[k] = hist_y[k][depth[k]];
      steps[k]--;
    end
    e.ok = ok; e.x = px[k]; e.y = py[k]; e.st = steps[k]; e.fd = fnd[k];
    if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
  endfunction

  task automatic check_pop(input int k);
    exp_t e;
    if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
      chk($sformatf("rsp_unexpected%0d", k), 1, 0);
    end else begin
      e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
      chk($sformatf("rsp_ok%0d", k), rsp_ok[k], e.ok);
      chk($sformatf("rsp_x%0d", k), x_pos[k], e.x);
      chk($sformatf("rsp_y%0d", k), y_pos[k], e.y);
      chk($sformatf("rsp_step%0d", k), step_cnt[k], e.st);
      chk($sformatf("rsp_found%0d", k), found[k], e.fd);
    end
  endtask

  // Scoreboard monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    if (rsp_valid[0]) check_pop(0);
    if (rsp_valid[1]) check_pop(1);
  end

  task automatic wr_cell(input int k, input int x, input int y, input bit open);
    @(negedge clk);
    wr_en[k] = 1'b1; wr_x[k] = 4'(x); wr_y[k] = 4'(y); wr_open[k] = open;
    @(posedge clk);
    #1 wr_en[k] = 1'b0;
    if (!(in_sess[k] && !fnd[k]) && x < GW && y < GH) mz[k][x][y] = open;
  endtask

  // mode 0: all open, 1: row 0 plus last column, 2: random with (0,0) open
  task automatic load(input int k, input int mode);
    bit o;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        case (mode)
          0:       o = 1'b1;
          1:       o = (y == 0) || (x == GW - 1);
          default: o = (x == 0 && y == 0) || ($urandom_range(3) != 0);
        endcase
        wr_cell(k, x, y, o);
      end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b0;
    model_reset(k);
    @(negedge clk);
    rst[k] = 1'b1;
  endtask

  task automatic do_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
    model_start(k);
  endtask

  task automatic do_cmd(input int k, input int dir);
    int g = 0;
    @(negedge clk);
    while (!cmd_ready[k] && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready[k]) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid[k] = 1'b1;
    cmd_dir[k]   = 3'(dir);
    model_cmd(k, dir);
    @(posedge clk);
    #1 cmd_valid[k] = 1'b0;
    @(negedge clk);
    chk("rsp_latency", rsp_valid[k], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; wr_en[k] = 1'b0; wr_x[k] = '0; wr_y[k] = '0; wr_open[k] = 1'b0;
      start[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_dir[k] = '0;
      model_reset(k);
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", busy[k], 0);
      chk("reset_ready", cmd_ready[k], 0);
      chk("reset_rsp_valid", rsp_valid[k], 0);
      chk("reset_pos", {x_pos[k], y_pos[k]}, 0);
      chk("reset_step", step_cnt[k], 0);
      chk("reset_found", found[k], 0);
    end
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;

    // First move right, edge rejections, no-op, illegal codes, visited and backtrack.
    load(0, 0);
    do_start(0);
    chk("start_busy", busy[0], 1);
    do_cmd(0, 3);
    do_start(0);
    do_cmd(0, 0);
    do_cmd(0, 2);
    do_cmd(0, 6);
    do_cmd(0, 4);
    do_cmd(0, 5);
    do_start(0);
    do_cmd(0, 3);
    do_cmd(0, 2);
    do_cmd(0, 7);
    do_cmd(0, 7);

    // Corridor to the far corner: 18 moves reach the goal and park in DONE.
    do_reset(0);
    load(0, 1);
    do_start(0);
    for (int i = 0; i < 9; i++) do_cmd(0, 3);
    for (int i = 0; i < 9; i++) do_cmd(0, 1);
    @(negedge clk);
    chk("done_ready", cmd_ready[0], 0);
    chk("done_busy", busy[0], 0);
    chk("done_found", found[0], 1);
    chk("done_step", step_cnt[0], 18);
    @(negedge clk);
    chk("done_found_hold", found[0], 1);

    // A write during a live session must not open the wall below (0,0).
    do_start(0);
    chk("restart_found", found[0], 0);
    wr_cell(0, 0, 1, 1'b1);
    do_cmd(0, 1);

    // Random mazes and commands.
    for (int m = 0; m < 3; m++) begin
      do_reset(0);
      load(0, 2);
      for (int s = 0; s < 4; s++) begin
        do_start(0);
        for (int c = 0; c < 30 && !fnd[0]; c++) begin
          if ($urandom_range(9) == 0) wr_cell(0, $urandom_range(11), $urandom_range(11), 1'b1);
          if ($urandom_range(3) == 0) do_cmd(0, $urandom_range(7));
          else do_cmd(0, $urandom_range(3));
        end
      end
    end

    // Reset while a response is on the bus.
    do_reset(0);
    load(0, 0);
    do_start(0);
    do_cmd(0, 3);
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_dir[0] = 3'd1;
    model_cmd(0, 1);
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    rst[0] = 1'b0;
    model_reset(0);
    #1;
    chk("midrst_rsp_valid", rsp_valid[0], 0);
    chk("midrst_x", x_pos[0], 0);
    chk("midrst_y", y_pos[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_step", step_cnt[0], 0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_no_ready", cmd_ready[0], 0);
    do_start(0);
    do_cmd(0, 3);
    do_cmd(0, 1);

    // Step limit of 4 on the second instance.
    load(1, 0);
    do_start(1);
    for (int i = 0; i < 5; i++) do_cmd(1, 3);
    do_cmd(1, 7);
    do_cmd(1, 3);
    do_cmd(1, 1);

    repeat (4) @(negedge clk);
    chk("sb_drain0", sbq0.size(), 0);
    chk("sb_drain1", sbq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_move_responder.md
MAZE_MOVE_RESPONDER -- requirements
Module: maze_move_responder

Interface
REQ-001 SHALL have parameter W, default 10, giving the maze width in cells, with a maximum of 16.
REQ-002 SHALL have parameter H, default 10, giving the maze height in cells, with a maximum of 16.
REQ-003 SHALL have parameter MAX_STEPS, default 50, giving the maximum number of accepted moves per session, with a maximum of 127.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port maze_wr_en, input, 1 bit: maze cell write strobe.
REQ-007 SHALL have ports maze_wr_x and maze_wr_y, input, 4 bits each: coordinates of the cell being written.
REQ-008 SHALL have port maze_wr_open, input, 1 bit: 1 means the cell is open, 0 means wall.
REQ-009 SHALL have port start, input, 1 bit: begins a session at (0,0).
REQ-010 SHALL have ports cmd_valid (input, 1 bit), cmd_dir (input, 3 bits) and cmd_ready (output, 1 bit): the move command handshake.
REQ-011 SHALL have ports rsp_valid (output, 1 bit) and rsp_ok (output, 1 bit): the move response.
REQ-012 SHALL have ports x_pos and y_pos, output, 4 bits each: current position.
REQ-013 SHALL have port found, output, 1 bit: goal reached.
REQ-014 SHALL have port step_cnt, output, 7 bits: number of accepted moves.
REQ-015 SHALL have port busy, output, 1 bit: a session is active.

Function
REQ-016 SHALL use direction codes 000 up (y-1), 001 down (y+1), 010 left (x-1), 011 right (x+1), 110 no-op, 111 backtrack; 100 and 101 are illegal.
REQ-017 SHALL hold a W x H open/wall bitmap and a W x H visited bitmap.
REQ-018 SHALL implement states IDLE, RUN, RESP and DONE.
REQ-019 SHALL in IDLE and DONE write maze[maze_wr_x][maze_wr_y] = maze_wr_open on maze_wr_en; writes in RUN or RESP, or with out-of-range coordinates, are ignored.
REQ-020 SHALL on start in any state: clear visited, set position (0,0), mark (0,0) visited, set step_cnt = 0 and found = 0, and enter RUN the next cycle; start has priority over cmd_valid.
REQ-021 SHALL assert cmd_ready only in RUN; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-022 SHALL move to RESP on acceptance; in RESP, rsp_valid = 1 for exactly one cycle, one cycle after acceptance, and x_pos/y_pos show the updated position.
REQ-023 SHALL accept a move (rsp_ok = 1) only when all hold: target cell in range, target cell open, target cell not visited, step_cnt < MAX_STEPS. On acceptance: update position, mark target visited, increment step_cnt.
REQ-024 SHALL on a rejected move set rsp_ok = 0 and leave position, visited and step_cnt unchanged; a rejection at the grid edge never wraps around.
REQ-025 SHALL answer no-op with rsp_ok = 1 and no state change; illegal codes SHALL give rsp_ok = 0.
REQ-026 SHALL, when an accepted move lands on (W-1,H-1), set found = 1 in the RESP cycle and go RESP -> DONE; otherwise RESP -> RUN.
REQ-027 SHALL saturate step_cnt at MAX_STEPS and never wrap.
REQ-028 SHALL drive busy = 1 in RUN and RESP; found SHALL hold until start or reset.

Reset
REQ-029 SHALL on rst low, immediately: state IDLE, all outputs 0, maze all walls, visited all 0, backtrack stack empty.
REQ-030 SHALL, if reset is asserted mid-session, abort the session with no response issued and require a new start afterwards.

Configuration
REQ-031 SHALL, with MAZE_BACKTRACK_EN defined, keep a MAX_STEPS-deep stack of prior positions; code 111 pops the stack, restores that position, clears the visited bit of the vacated cell, decrements step_cnt and gives rsp_ok = 1.
REQ-032 SHALL, with MAZE_BACKTRACK_EN defined, answer 111 on an empty stack with rsp_ok = 0 and no change.
REQ-033 SHALL, without MAZE_BACKTRACK_EN, implement no stack and treat 111 as illegal (rsp_ok = 0).

Verification
REQ-034 SHALL cover: all cells open, start, cmd_dir=011 -> rsp_valid one cycle later, rsp_ok=1, x_pos=1, y_pos=0, step_cnt=1.
REQ-035 SHALL cover: at (0,0), cmd_dir=000 -> rsp_ok=0, position stays (0,0), step_cnt=0.
REQ-036 SHALL cover: right then left -> second response rsp_ok=0 because (0,0) is visited; with MAZE_BACKTRACK_EN, 111 -> rsp_ok=1, position (0,0), step_cnt=0.
REQ-037 SHALL cover: open straight corridor to (9,9), issue 18 moves -> found=1 at 18th response, step_cnt=18, state DONE, cmd_ready=0.
REQ-038 SHALL cover: MAX_STEPS=4, 5 legal moves -> 5th response rsp_ok=0, step_cnt=4.
REQ-039 SHALL cover: rst low during RESP -> rsp_valid=0 immediately, x_pos=0, y_pos=0, busy=0, maze cleared to all walls.
